axil_reg_if_rd: RTL
===================

AXIL_REG_IF_RD -- requirements
Module: axil_reg_if_rd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI-lite and register data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 4: cycles reg_rd_en stays asserted, absent reg_rd_wait, before forced completion; minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axil_araddr  input  ADDR_WIDTH  read address.
REQ-007 SHALL have port s_axil_arprot  input  3  protection; ignored.
REQ-008 SHALL have port s_axil_arvalid  input  1  address valid.
REQ-009 SHALL have port s_axil_arready  output  1  address ready.
REQ-010 SHALL have port s_axil_rdata  output  DATA_WIDTH  read data.
REQ-011 SHALL have port s_axil_rresp  output  2  read response.
REQ-012 SHALL have port s_axil_rvalid  output  1  read data valid.
REQ-013 SHALL have port s_axil_rready  input  1  read data ready.
REQ-014 SHALL have port reg_rd_addr  output  ADDR_WIDTH  registered read address.
REQ-015 SHALL have port reg_rd_en  output  1  register read strobe, held until completion.
REQ-016 SHALL have port reg_rd_data  input  DATA_WIDTH  register read data, valid with reg_rd_ack.
REQ-017 SHALL have port reg_rd_wait  input  1  high freezes the timeout counter.
REQ-018 SHALL have port reg_rd_ack  input  1  read complete; sampled only while reg_rd_en is high.

Function
REQ-019 SHALL implement states IDLE, READ and RESP; s_axil_arready SHALL be high only in IDLE and not in reset.
REQ-020 SHALL, on an AR handshake in IDLE, register araddr to reg_rd_addr, load the timeout counter with TIMEOUT-1 and enter READ; reg_rd_en SHALL be high in the next cycle.
REQ-021 SHALL hold reg_rd_en high and reg_rd_addr stable for every cycle in READ, and hold reg_rd_en low in IDLE and RESP.
REQ-022 SHALL, in READ with reg_rd_ack high, capture reg_rd_data into s_axil_rdata, set rresp to 2'b00, and enter RESP.
REQ-023 SHALL, in READ with reg_rd_ack low and counter 0, set s_axil_rdata to 0, set rresp per REQ-031/032, and enter RESP (timeout).
REQ-024 SHALL, in READ with no ack, no timeout and reg_rd_wait low, decrement the counter; with reg_rd_wait high the counter SHALL hold, so no timeout ever occurs while wait is high.
REQ-025 SHALL give reg_rd_ack priority over timeout when both occur in the same cycle: data captured, rresp 2'b00.
REQ-026 SHALL assert s_axil_rvalid exactly while in RESP, hold rdata and rresp stable until rready, and return to IDLE on the R handshake.
REQ-027 SHALL ignore reg_rd_ack, reg_rd_data and reg_rd_wait outside READ.
REQ-028 SHALL, with zero wait and an immediate ack, sustain one read per 3 cycles; with no ack, reg_rd_en SHALL be high for exactly TIMEOUT cycles.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, reg_rd_en 0, s_axil_rvalid 0, s_axil_arready 0, rresp 2'b00 and rdata 0; reset mid-READ or mid-RESP SHALL drop the transaction silently.
REQ-030 SHALL leave reg_rd_addr and the counter unreset.

Configuration
REQ-031 SHALL, with AXIL_REG_IF_RD_SLVERR_EN defined, return rresp 2'b10 (SLVERR) on a timeout.
REQ-032 SHALL, without AXIL_REG_IF_RD_SLVERR_EN, return rresp 2'b00 with rdata 0 on a timeout; rresp is then constant 2'b00.

Structure
REQ-033 SHALL take the response constants (OKAY 2'b00, SLVERR 2'b10) and the state encoding from the shared package axil_reg_if_pkg.
REQ-034 SHALL place the load/decrement/zero-detect timeout counter in the sub-module axil_reg_if_timeout, reusable by the write-side block.

Verification
REQ-035 Bench SHALL cover: AR addr 0x10 -> reg_rd_en high one cycle later with reg_rd_addr 0x10; ack on the first en cycle with data 0xDEADBEEF -> rvalid with rdata 0xDEADBEEF, rresp 00.
REQ-036 Bench SHALL cover: TIMEOUT=4, no ack, wait low -> en high exactly 4 cycles, then rdata 0 with rresp 10 (macro defined) or 00 (macro undefined).
REQ-037 Bench SHALL cover: wait high for 20 cycles, then ack with 0x1234 -> no timeout, rdata 0x1234, rresp 00.
REQ-038 Bench SHALL cover: ack coincident with counter 0 and data 0x55 -> rdata 0x55, rresp 00.
REQ-039 Bench SHALL cover: rready held low for 5 cycles -> rvalid and rdata stable and arready low throughout; arready high the cycle after the handshake.
REQ-040 Bench SHALL cover: rst pulsed during READ -> en 0, rvalid 0, arready high after rst falls, and the next read completes normally.

Source files
------------

// File: rtl/axil_reg_if_pkg.sv
// rtl/axil_reg_if_pkg.sv - shared response codes and state encoding for the AXI-lite register bridge
package axil_reg_if_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axil_reg_if_timeout.sv
// rtl/axil_reg_if_timeout.sv - load/decrement/zero-detect timeout counter shared by the read and write bridges
module axil_reg_if_timeout #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  // Deliberately unreset: it is always loaded before its value matters.
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/axil_reg_if_rd.sv
// rtl/axil_reg_if_rd.sv - AXI-lite read channel to register read strobe bridge with timeout
// Define AXIL_REG_IF_RD_SLVERR_EN to answer timed-out reads with SLVERR instead of OKAY.
module axil_reg_if_rd
  import axil_reg_if_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  rd_state_t state, state_next;
  logic      cnt_load, cnt_dec, cnt_zero;
  logic      capture, timeout;
  logic      unused_prot;

  assign unused_prot = ^s_axil_arprot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ack wins over timeout; a held wait blocks both the decrement and the timeout.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axil_arvalid) begin
          cnt_load   = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (reg_rd_ack) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else if (!reg_rd_wait) begin
          if (cnt_zero) begin
            timeout    = 1'b1;
            state_next = ST_RESP;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (s_axil_rready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  axil_reg_if_timeout #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk        (clk),
    .load       (cnt_load),
    .load_value (CNT_LOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && s_axil_arvalid && !rst) begin
      reg_rd_addr <= s_axil_araddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_rdata <= '0;
    end else if (capture) begin
      s_axil_rdata <= reg_rd_data;
    end else if (timeout) begin
      s_axil_rdata <= '0;
    end
  end

`ifdef AXIL_REG_IF_RD_SLVERR_EN
  logic [1:0] rresp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rresp_q <= RESP_OKAY;
    end else if (capture) begin
      rresp_q <= RESP_OKAY;
    end else if (timeout) begin
      rresp_q <= RESP_SLVERR;
    end
  end

  assign s_axil_rresp = rresp_q;
`else
  assign s_axil_rresp = RESP_OKAY;
`endif

  // Handshake outputs are gated by rst so they are quiet for the whole reset pulse.
  assign s_axil_arready = (state == ST_IDLE) && !rst;
  assign s_axil_rvalid  = (state == ST_RESP) && !rst;
  assign reg_rd_en      = (state == ST_READ) && !rst;

endmodule
